// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one radix-2 shift-add or restoring
// shift-subtract step per cycle, followed by a single sign-correction cycle.
module mdu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 stallreq_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi, lo, opnd;
  logic               is_div, neg_q, neg_r;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, trial;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;
  logic [WIDTH-1:0]   rem_fix, quo_fix;
  logic [2*WIDTH-1:0] prod_fix;

  // op_i[0] selects the signed variants; magnitudes feed the unsigned datapath
  always_comb begin
    a_neg = op_i[0] & opa_i[WIDTH-1];
    b_neg = op_i[0] & opb_i[WIDTH-1];
    a_mag = a_neg ? -opa_i : opa_i;
    b_mag = b_neg ? -opb_i : opb_i;
  end

  // hi/lo hold {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    trial  = {hi, lo[WIDTH-1]} - {1'b0, opnd};
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      if (!trial[WIDTH]) begin
        hi_nxt = trial[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = {hi[WIDTH-2:0], lo[WIDTH-1]};
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    rem_fix  = neg_r ? -hi : hi;
    quo_fix  = neg_q ? -lo : lo;
    prod_fix = neg_q ? -{hi, lo} : {hi, lo};
  end

  always_comb stallreq_o = start_i & ~ready_o;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            is_div <= op_i[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            cnt    <= '0;
            busy_o <= 1'b1;
            if (op_i[1] && opb_i == '0) begin
              result_o <= {opa_i, {WIDTH{1'b1}}};
              ready_o  <= 1'b1;
              state    <= DONE;
            end else begin
              hi    <= '0;
              lo    <= op_i[1] ? a_mag : b_mag;
              opnd  <= op_i[1] ? b_mag : a_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (annul_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (cnt == CNT_W'(WIDTH)) begin
            state <= FIX;
          end else begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (annul_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            result_o <= is_div ? {rem_fix, quo_fix} : prod_fix;
            ready_o  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: 32-bit and 8-bit instances, expected results
// queued at issue and compared when ready_o pulses.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        resetn = 1'b1;

  logic        start = 1'b0, annul = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] opa = '0, opb = '0;
  logic [63:0] result;
  logic        ready, busy, stall;

  logic        start8 = 1'b0, annul8 = 1'b0;
  logic [1:0]  op8 = '0;
  logic [7:0]  opa8 = '0, opb8 = '0;
  logic [15:0] result8;
  logic        ready8, busy8, stall8;

  int unsigned n_pass = 0, n_total = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp8_q[$];

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .start_i(start), .op_i(op), .opa_i(opa),
    .opb_i(opb), .annul_i(annul), .result_o(result), .ready_o(ready),
    .busy_o(busy), .stallreq_o(stall));

  mdu_iter #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .resetn(resetn), .start_i(start8), .op_i(op8), .opa_i(opa8),
    .opb_i(opb8), .annul_i(annul8), .result_o(result8), .ready_o(ready8),
    .busy_o(busy8), .stallreq_o(stall8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference built on native signed 64-bit arithmetic (truncating division)
  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a,
                                        input logic [63:0] b, input int w);
    logic [63:0] mw, m2, res;
    longint sa, sb, q, r;
    mw = (64'd1 << w) - 64'd1;
    m2 = (2 * w >= 64) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    a  = a & mw;
    b  = b & mw;
    sa = longint'(a) - (a[w-1] ? longint'(64'd1 << w) : 64'sd0);
    sb = longint'(b) - (b[w-1] ? longint'(64'd1 << w) : 64'sd0);
    case (o)
      2'd0: res = (a * b) & m2;
      2'd1: res = 64'(sa * sb) & m2;
      2'd2: res = (b == 0) ? ((a << w) | mw) : (((a % b) << w) | (a / b));
      default: begin
        if (b == 0) res = (a << w) | mw;
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = ((64'(r) & mw) << w) | (64'(q) & mw);
        end
      end
    endcase
    return res;
  endfunction

  // Called at a negedge with the 32-bit unit idle; returns at a negedge, idle.
  task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    int lat = 0;
    int exp_lat;
    exp_lat = (o[1] && b == 32'd0) ? 1 : 35;
    exp_q.push_back(model(o, {32'd0, a}, {32'd0, b}, 32));
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; opa = $urandom; opb = $urandom; op = 2'($urandom);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result, exp_q.pop_front());
    @(negedge clk);
    check({tag, "_pulse"}, {63'd0, ready}, 64'd0);
  endtask

  initial begin
    logic seen_ready, seen_busy;

    #1 resetn = 1'b0;
    #2;
    check("rst_result", result, 64'd0);
    check("rst_flags", {61'd0, ready, busy, stall}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    run32("mult_neg", 2'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_neg_val", result, 64'hFFFF_FFFF_FFFF_FFFA);
    run32("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_val", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run32("divu", 2'd2, 32'hFFFF_FFF9, 32'd2);
    check("divu_val", result, 64'h0000_0001_7FFF_FFFC);
    run32("divu_zero", 2'd2, 32'h1234_5678, 32'd0);
    check("divu_zero_val", result, 64'h1234_5678_FFFF_FFFF);
    run32("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_val", result, 64'h0000_0000_8000_0000);
    run32("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run32("div_pos_neg", 2'd3, 32'd100, 32'hFFFF_FFF9);
    run32("div_zero_s", 2'd3, 32'hDEAD_BEEF, 32'd0);
    for (int k = 0; k < 4; k++) begin
      run32("rand", 2'(k), $urandom, $urandom | 32'd1);
    end

    // annul mid-CALC, then an immediate follow-up op
    start = 1'b1; op = 2'd0; opa = 32'h0001_0000; opb = 32'h0000_0300;
    @(posedge clk); #1 start = 1'b0;
    seen_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_ready |= ready;
    end
    annul = 1'b1;
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    seen_ready |= ready;
    check("annul_busy", {63'd0, busy}, 64'd0);
    check("annul_noready", {63'd0, seen_ready}, 64'd0);
    run32("after_annul", 2'd0, 32'd7, 32'd6);
    check("after_annul_val", result, 64'd42);

    // annul in IDLE blocks the start
    start = 1'b1; annul = 1'b1; op = 2'd0; opa = 32'd3; opb = 32'd3;
    #1 check("stall_idle", {63'd0, stall}, 64'd1);
    @(posedge clk); #1 start = 1'b0; annul = 1'b0;
    @(negedge clk);
    check("annul_idle_busy", {63'd0, busy}, 64'd0);

    // asynchronous reset with the clock stopped mid-CALC
    start = 1'b1; op = 2'd1; opa = 32'h0000_1234; opb = 32'hFFFF_0000;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", {63'd0, busy}, 64'd1);
    clk_run = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("async_rst_result", result, 64'd0);
    check("async_rst_flags", {62'd0, ready, busy}, 64'd0);
    #3 resetn = 1'b1;
    #3 clk_run = 1'b1;
    seen_ready = 1'b0;
    seen_busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_ready |= ready;
      seen_busy |= busy;
    end
    check("post_rst_noready", {63'd0, seen_ready}, 64'd0);
    check("post_rst_nobusy", {63'd0, seen_busy}, 64'd0);

    // 8-bit: start held high gives a 12-cycle back-to-back cadence
    repeat (3) exp8_q.push_back(model(2'd1, 64'h80, 64'h80, 8));
    start8 = 1'b1; op8 = 2'd1; opa8 = 8'h80; opb8 = 8'h80;
    #1 check("b2b_stall0", {62'd0, busy8, stall8}, 64'd1);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", k), {63'd0, ready8}, {63'd0, (k % 12) == 11});
      check($sformatf("b2b_busy_%0d", k), {63'd0, busy8}, {63'd0, (k % 12) != 0});
      check($sformatf("b2b_stall_%0d", k), {63'd0, stall8}, {63'd0, (k % 12) != 11});
      if (ready8 && exp8_q.size() > 0)
        check($sformatf("b2b_res_%0d", k), {48'd0, result8}, exp8_q.pop_front());
    end
    check("b2b_all_done", 64'(exp8_q.size()), 64'd0);
    check("b2b_val", {48'd0, result8}, 64'h4000);
    start8 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal range 8..64, even.
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  request a new operation; sampled only in IDLE.
REQ-006 op_i  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 opa_i  input  WIDTH  multiplicand or dividend.
REQ-008 opb_i  input  WIDTH  multiplier or divisor.
REQ-009 annul_i  input  1  cancel the in-flight operation.
REQ-010 result_o  output  2*WIDTH  {HI,LO}; HI is bits [2W-1:W].
REQ-011 ready_o  output  1  one-cycle pulse; result_o is valid in that cycle.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 stallreq_o  output  1  combinational (start_i & ~ready_o); asserted when the pipeline must hold.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-015 IDLE: start_i=1 at an edge SHALL capture op_i, capture |opa| and |opb| (the magnitudes, for signed ops) and their signs, clear the counter, and go to CALC.
REQ-016 DIV/DIVU with opb_i=0 at accept SHALL go directly to DONE with HI=opa_i (raw value) and LO=all ones; no iterations are performed.
REQ-017 CALC SHALL perform exactly one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; the counter SHALL increment once per step.
REQ-018 After step WIDTH the FSM SHALL go to FIX.
REQ-019 FIX SHALL apply sign correction and then go to DONE.
REQ-020 Sign correction, MULT: the 2W-bit product SHALL be negated if the operand signs differ.
REQ-021 Sign correction, DIV: the quotient SHALL be negated if the operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-022 Division result mapping SHALL be HI=remainder, LO=quotient; multiplication result mapping SHALL be the full 2W-bit product {HI,LO}.
REQ-023 DIV of -2^(W-1) by -1 SHALL give LO=2^(W-1) (wrapped) and HI=0, with no error flag.
REQ-024 DONE SHALL hold ready_o=1 for exactly one cycle and then return to IDLE.
REQ-025 Latency: on a normal op, ready_o SHALL be high in the cycle after edge WIDTH+2, counting the accepting edge as edge 0. On divide-by-zero, ready_o SHALL be high in the cycle after the accepting edge.
REQ-026 result_o SHALL hold its value after DONE and change only during a later operation; the value is architecturally meaningful only while ready_o=1.
REQ-027 start_i SHALL be ignored in CALC, FIX and DONE; operand inputs SHALL be ignored after acceptance.
REQ-028 annul_i=1 in CALC or FIX SHALL force IDLE at the next edge, with no ready_o pulse.
REQ-029 annul_i=1 in IDLE SHALL override start_i, so no operation is accepted.
REQ-030 annul_i SHALL have no effect in DONE; the pulse still occurs.
REQ-031 All arithmetic SHALL be modulo 2^(2W) for the product and modulo 2^W per half for division; the unit SHALL raise no overflow or exception output.

Reset
REQ-032 resetn=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, counter 0, result_o=0, ready_o=0, busy_o=0.
REQ-033 Reset asserted mid-operation SHALL abandon the operation; no ready_o pulse SHALL follow deassertion.
REQ-034 The first start_i SHALL be accepted at the first rising edge after resetn deassertion.

Verification (WIDTH=32 unless stated)
REQ-035 MULT opa=0xFFFFFFFE(-2), opb=0x00000003 -> ready_o on the 35th cycle after accept, result_o=0xFFFFFFFF_FFFFFFFA.
REQ-036 DIV opa=0xFFFFFFF9(-7), opb=2 -> HI=0xFFFFFFFF(-1), LO=0xFFFFFFFD(-3). DIVU same operands -> HI=1, LO=0x7FFFFFFC.
REQ-037 DIVU opa=0x12345678, opb=0 -> ready_o the cycle after accept, HI=0x12345678, LO=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> HI=0, LO=0x80000000.
REQ-038 MULTU start, annul_i pulsed at cycle 10 of CALC -> no ready_o pulse, busy_o low the next cycle; an immediate new MULTU 7x6 -> LO=42, HI=0.
REQ-039 resetn pulled low at CALC cycle 5 with clk stopped -> outputs zero at once; release, then no ready_o for 40 cycles.
REQ-040 WIDTH=8: MULT 0x80 x 0x80 -> result_o=0x4000 on the 11th cycle after accept; start_i held high continuously -> back-to-back ops with exactly one idle cycle between each DONE and the next accept.
